// File: rtl/dataflow_mem_arbiter.sv
// dataflow_mem_arbiter
//   Round-robin arbiter that hands one shared memory write channel to one of
//   PROC_NUM dataflow processes at a time. The owner streams a burst of
//   beats. The burst length is latched at grant time and clamped to
//   1..BURST_MAX. A sticky alarm reports backpressure that lasts long enough
//   to suggest a deadlock.
// Ports
//   clock, reset          : rising-edge clock, async active-high reset
//   req_vec/req_len       : per-process burst request and length (8b each)
//   req_data/_valid       : per-process beat data and valid
//   data_ready            : per-process beat accept (only the owner)
//   grant                 : registered one-hot owner, 0 when idle
//   mem_data/valid/ready  : shared memory channel handshake
//   burst_done            : pulse on the last beat of a burst
//   stall_alarm           : sticky, set after STALL_LIMIT stalled beats
module dataflow_mem_arbiter #(
  parameter int PROC_NUM    = 2,
  parameter int DATA_W      = 32,
  parameter int BURST_MAX   = 16,
  parameter int STALL_LIMIT = 1024
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [PROC_NUM-1:0]        req_vec,
  input  logic [PROC_NUM*8-1:0]      req_len,
  input  logic [PROC_NUM*DATA_W-1:0] req_data,
  input  logic [PROC_NUM-1:0]        req_data_valid,
  output logic [PROC_NUM-1:0]        data_ready,
  output logic [PROC_NUM-1:0]        grant,
  output logic [DATA_W-1:0]          mem_data,
  output logic                       mem_valid,
  input  logic                       mem_ready,
  output logic                       burst_done,
  output logic                       stall_alarm
);

  localparam int PW = (PROC_NUM > 1) ? $clog2(PROC_NUM) : 1;
  localparam int SW = $clog2(STALL_LIMIT + 1);
  localparam logic [7:0]    BMAX = 8'(BURST_MAX);
  localparam logic [SW-1:0] SLIM = SW'(STALL_LIMIT);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                state_q, state_d;
  logic [PROC_NUM-1:0]   grant_q, grant_d;
  logic [PW-1:0]         gidx_q, gidx_d;
  logic [PW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [7:0]            beat_cnt_q, beat_cnt_d;
  logic [SW-1:0]         stall_cnt_q, stall_cnt_d;
  logic                  stall_alarm_q, stall_alarm_d;

  logic                  pick_found;
  logic [PW-1:0]         pick_idx, cand;
  logic [PROC_NUM-1:0]   pick_oh;
  logic [7:0]            raw_len, pick_len;
  logic                  beat;

  // Round-robin pick: first requester at or after rr_ptr, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    pick_oh    = '0;
    raw_len    = '0;
    for (int k = 0; k < PROC_NUM; k++) begin
      cand = PW'((int'(rr_ptr_q) + k) % PROC_NUM);
      if (!pick_found && req_vec[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
    for (int k = 0; k < PROC_NUM; k++) begin
      if (pick_idx == PW'(k)) begin
        pick_oh[k] = 1'b1;
        raw_len    = req_len[k*8 +: 8];
      end
    end
    // Zero-length requests still move one beat; long ones are capped.
    if (raw_len == 8'd0)     pick_len = 8'd1;
    else if (raw_len > BMAX) pick_len = BMAX;
    else                     pick_len = raw_len;
  end

  // Channel mux: only the owner sees mem_ready, everything is 0 when idle.
  always_comb begin
    mem_valid  = 1'b0;
    mem_data   = '0;
    data_ready = '0;
    if (state_q == BURST) begin
      for (int k = 0; k < PROC_NUM; k++) begin
        if (gidx_q == PW'(k)) begin
          mem_valid     = req_data_valid[k];
          mem_data      = req_data[k*DATA_W +: DATA_W];
          data_ready[k] = mem_ready;
        end
      end
    end
  end

  assign beat       = mem_valid && mem_ready;
  assign burst_done = beat && (beat_cnt_q == 8'd1);

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    gidx_d        = gidx_q;
    rr_ptr_d      = rr_ptr_q;
    beat_cnt_d    = beat_cnt_q;
    stall_cnt_d   = stall_cnt_q;
    stall_alarm_d = stall_alarm_q;
    case (state_q)
      IDLE: begin
        stall_cnt_d = '0;
        if (pick_found) begin
          state_d    = BURST;
          grant_d    = pick_oh;
          gidx_d     = pick_idx;
          beat_cnt_d = pick_len;
        end
      end
      BURST: begin
        if (beat) begin
          stall_cnt_d = '0;
          beat_cnt_d  = beat_cnt_q - 8'd1;
          if (beat_cnt_q == 8'd1) begin
            state_d  = IDLE;
            grant_d  = '0;
            rr_ptr_d = (gidx_q == PW'(PROC_NUM - 1)) ? '0 : gidx_q + 1'b1;
          end
        end else if (mem_valid && stall_cnt_q != SLIM) begin
          // Cycles without valid neither count nor clear the stall run.
          stall_cnt_d = stall_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Alarm flops on the same edge the counter hits the limit.
    if (stall_cnt_d == SLIM) stall_alarm_d = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      gidx_q        <= '0;
      rr_ptr_q      <= '0;
      beat_cnt_q    <= '0;
      stall_cnt_q   <= '0;
      stall_alarm_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      gidx_q        <= gidx_d;
      rr_ptr_q      <= rr_ptr_d;
      beat_cnt_q    <= beat_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
      stall_alarm_q <= stall_alarm_d;
    end
  end

  assign grant       = grant_q;
  assign stall_alarm = stall_alarm_q;

endmodule
